// File: rtl/addsub_pipe.sv
// Add/subtract/accumulate unit with a one-deep valid/ready output register.
// Define ADDSUB_SAT_EN to saturate results (and accumulator writes) on signed overflow.
module addsub_pipe #(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [dw-1:0] dataa,
  input  logic [dw-1:0] datab,
  input  logic [1:0]    op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [dw-1:0] result,
  output logic          carry,
  output logic          ovf
);

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_ADD  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam int MSB = dw - 1;
  localparam logic [dw-1:0] SAT_MAX = {1'b0, {(dw-1){1'b1}}};
  localparam logic [dw-1:0] SAT_MIN = {1'b1, {(dw-1){1'b0}}};

  logic          valid_q;
  logic [dw-1:0] result_q, result_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic [dw-1:0] acc_q, acc_d;

  logic [dw-1:0] opa, opb, raw;
  logic [dw:0]   sum, diff;
  logic          accept;
  op_e           op_sel;

  assign op_sel   = op_e'(op);
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // The accumulate op reuses the adder with ACC as the A operand.
  assign opa  = (op_sel == OP_ACC) ? acc_q : dataa;
  assign opb  = (op_sel == OP_ACC) ? dataa : datab;
  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    raw     = dataa;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_sel)
      OP_SUB: begin
        raw     = diff[dw-1:0];
        carry_d = diff[dw];
        ovf_d   = (opa[MSB] != opb[MSB]) && (diff[MSB] != opa[MSB]);
      end
      OP_ADD, OP_ACC: begin
        raw     = sum[dw-1:0];
        carry_d = sum[dw];
        ovf_d   = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]);
      end
      default: begin
        raw     = dataa;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase

`ifdef ADDSUB_SAT_EN
    // On overflow the true result lies beyond the limit on A's side.
    result_d = ovf_d ? (opa[MSB] ? SAT_MIN : SAT_MAX) : raw;
`else
    result_d = raw;
`endif

    acc_d = acc_q;
    if (op_sel == OP_ACC)  acc_d = result_d;
    if (op_sel == OP_LOAD) acc_d = dataa;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
    end else if (out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule
